// File: rtl/main_bus_ctrl.sv
// rtl/main_bus_ctrl.sv - main bus controller: instruction forwarding, slave bus arbitration, memory access sequencing
module main_bus_ctrl #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int IW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          test_mode,
    input  logic          master_valid,
    input  logic [IW-1:0] master_instruction,
    output logic          master_ready,
    output logic          slave_request,
    output logic [IW-1:0] slave_instruction,
    input  logic          bus_request,
    input  logic [AW-1:0] slave_address,
    input  logic [DW-1:0] slave_wdata,
    input  logic          slave_write,
    output logic          bus_grant,
    output logic [AW-1:0] address,
    output logic [DW-1:0] data,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          data_ready,
    output logic          slave_ready,
    output logic          bus_error
);

    typedef enum logic [1:0] {IDLE, GRANT, ACCESS, DONE} state_t;

    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          lat_write;
    logic [DW-1:0] rd_hold;
    logic [7:0]    tcnt;

    logic          start;
    logic          ack_hit;
    logic          expire;

    logic          grant_d;
    logic          read_d;
    logic          write_d;
    logic          ready_d;
    logic          dready_d;
    logic          err_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] data_d;
    logic [DW-1:0] hold_d;
    logic [7:0]    tcnt_d;

    assign start   = (state == IDLE) && bus_request && !test_mode;
    assign ack_hit = (state == ACCESS) && mem_ack;
    assign expire  = (state == ACCESS) && !mem_ack && (tcnt == TLAST);

    assign master_ready = !slave_request;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = GRANT;
            GRANT:   state_next = ACCESS;
            ACCESS:  if (ack_hit || expire) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead from the next state and then registered.
    always_comb begin
        grant_d  = (state_next != IDLE);
        read_d   = (state_next == ACCESS) && !lat_write;
        write_d  = (state_next == ACCESS) && lat_write;
        ready_d  = (state_next == DONE);
        dready_d = ack_hit && !lat_write;
        err_d    = expire;
        tcnt_d   = (state == ACCESS) ? tcnt + 8'd1 : 8'd0;
        if (start) begin
            addr_d = slave_address;
        end else if (state_next == IDLE) begin
            addr_d = '0;
        end else begin
            addr_d = lat_addr;
        end
        data_d = data;
        hold_d = rd_hold;
        if (start) begin
            data_d = slave_write ? slave_wdata : rd_hold;
        end else if (ack_hit && !lat_write) begin
            data_d = mem_rdata;
            hold_d = mem_rdata;
        end else if (expire) begin
            data_d = '1;
            hold_d = '1;
        end else if (state == DONE) begin
            data_d = rd_hold;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_grant   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            slave_ready <= 1'b0;
            data_ready  <= 1'b0;
            bus_error   <= 1'b0;
            address     <= '0;
            data        <= '0;
            rd_hold     <= '0;
            tcnt        <= 8'd0;
        end else begin
            bus_grant   <= grant_d;
            mem_read    <= read_d;
            mem_write   <= write_d;
            slave_ready <= ready_d;
            data_ready  <= dready_d;
            bus_error   <= err_d;
            address     <= addr_d;
            data        <= data_d;
            rd_hold     <= hold_d;
            tcnt        <= tcnt_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
        end else if (start) begin
            lat_addr  <= slave_address;
            lat_wdata <= slave_wdata;
            lat_write <= slave_write;
        end
    end

    // An offer is only taken while nothing is pending, so set and clear never collide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slave_request     <= 1'b0;
            slave_instruction <= '0;
        end else if (master_valid && !slave_request) begin
            slave_request     <= 1'b1;
            slave_instruction <= master_instruction;
        end else if (start) begin
            slave_request     <= 1'b0;
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^lat_wdata;

endmodule

// File: tb/tb_main_bus_ctrl.sv
// tb/tb_main_bus_ctrl.sv - self-checking bench for main_bus_ctrl
module tb_main_bus_ctrl;

    localparam int DW      = 16;
    localparam int AW      = 16;
    localparam int IW      = 8;
    localparam int TIMEOUT = 15;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          test_mode = 1'b0;
    logic          master_valid = 1'b0;
    logic [IW-1:0] master_instruction = '0;
    logic          master_ready;
    logic          slave_request;
    logic [IW-1:0] slave_instruction;
    logic          bus_request = 1'b0;
    logic [AW-1:0] slave_address = '0;
    logic [DW-1:0] slave_wdata = '0;
    logic          slave_write = 1'b0;
    logic          bus_grant;
    logic [AW-1:0] address;
    logic [DW-1:0] data;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          data_ready;
    logic          slave_ready;
    logic          bus_error;

    main_bus_ctrl #(.DW(DW), .AW(AW), .IW(IW), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .test_mode(test_mode),
        .master_valid(master_valid), .master_instruction(master_instruction),
        .master_ready(master_ready), .slave_request(slave_request),
        .slave_instruction(slave_instruction), .bus_request(bus_request),
        .slave_address(slave_address), .slave_wdata(slave_wdata),
        .slave_write(slave_write), .bus_grant(bus_grant), .address(address),
        .data(data), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .data_ready(data_ready),
        .slave_ready(slave_ready), .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: pos is -1 when idle, 0 in the grant cycle, k in the k-th access cycle.
    int            pos = -1;
    bit            in_done = 1'b0;
    bit            m_err = 1'b0;
    bit            m_wr = 1'b0;
    bit            m_start = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_hold = '0;
    bit            m_pend = 1'b0;
    logic [IW-1:0] m_instr = '0;

    task automatic model_step();
        if (reset) begin
            pos = -1; in_done = 0; m_err = 0; m_wr = 0;
            m_addr = '0; m_wdata = '0; m_hold = '0; m_pend = 0; m_instr = '0;
        end else begin
            m_start = (pos < 0) && !in_done && bus_request && !test_mode;
            if (!m_pend && master_valid) begin
                m_pend = 1; m_instr = master_instruction;
            end else if (m_start) begin
                m_pend = 0;
            end
            if (in_done) begin
                in_done = 0;
            end else if (m_start) begin
                pos = 0; m_addr = slave_address; m_wdata = slave_wdata; m_wr = slave_write; m_err = 0;
            end else if (pos == 0) begin
                pos = 1;
            end else if (pos >= 1) begin
                if (mem_ack) begin
                    if (!m_wr) m_hold = mem_rdata;
                    pos = -1; in_done = 1; m_err = 0;
                end else if (pos == TIMEOUT) begin
                    m_hold = '1; pos = -1; in_done = 1; m_err = 1;
                end else begin
                    pos++;
                end
            end
        end
    endtask

    always @(posedge clock or posedge reset) model_step();

    int grant_cnt, rd_cnt, wr_cnt, dr_cnt, sr_cnt, err_cnt;

    task automatic clear_cnt();
        grant_cnt = 0; rd_cnt = 0; wr_cnt = 0; dr_cnt = 0; sr_cnt = 0; err_cnt = 0;
    endtask

    task automatic compare_cycle();
        bit            busy;
        logic [DW-1:0] exp_data;
        busy     = (pos >= 0) || in_done;
        exp_data = (busy && m_wr && !(in_done && m_err)) ? m_wdata : m_hold;
        chk("master_ready", master_ready, !m_pend);
        chk("slave_request", slave_request, m_pend);
        chk("slave_instruction", slave_instruction, m_instr);
        chk("bus_grant", bus_grant, busy);
        chk("address", address, busy ? m_addr : '0);
        chk("data", data, exp_data);
        chk("mem_read", mem_read, (pos >= 1) && !m_wr);
        chk("mem_write", mem_write, (pos >= 1) && m_wr);
        chk("slave_ready", slave_ready, in_done);
        chk("data_ready", data_ready, in_done && !m_wr && !m_err);
        chk("bus_error", bus_error, in_done && m_err);
        if (!reset) begin
            grant_cnt += int'(bus_grant);
            rd_cnt    += int'(mem_read);
            wr_cnt    += int'(mem_write);
            dr_cnt    += int'(data_ready);
            sr_cnt    += int'(slave_ready);
            err_cnt   += int'(bus_error);
        end
    endtask

    always @(negedge clock) compare_cycle();

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // delay < 0 means no ack at all; otherwise ack arrives on access cycle delay+1.
    task automatic txn(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic wr,
                       input int delay, input logic [DW-1:0] rd, input bit tm_mid);
        slave_address = a; slave_wdata = wd; slave_write = wr; bus_request = 1'b1;
        step();
        bus_request = 1'b0;
        step();
        chk("access_address", address, a);
        if (wr) chk("access_wdata", data, wd);
        if (tm_mid) test_mode = 1'b1;
        if (delay >= 0) begin
            repeat (delay) step();
            mem_ack = 1'b1; mem_rdata = rd;
            step();
            mem_ack = 1'b0; mem_rdata = '0;
        end else begin
            repeat (TIMEOUT) step();
        end
        step();
        test_mode = 1'b0;
    endtask

    initial begin
        clear_cnt();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_master_ready", master_ready, 1);
        chk("rst_slave_request", slave_request, 0);
        chk("rst_bus_grant", bus_grant, 0);
        chk("rst_address", address, 0);
        chk("rst_data", data, 0);

        master_valid = 1'b1; master_instruction = 8'hA5;
        step();
        master_valid = 1'b0;
        chk("instr_pending", slave_request, 1);
        chk("instr_value", slave_instruction, 8'hA5);
        master_valid = 1'b1; master_instruction = 8'h3C;
        step();
        step();
        master_valid = 1'b0;
        chk("instr_not_replaced", slave_instruction, 8'hA5);

        clear_cnt();
        txn(16'h1234, 16'h0000, 1'b0, 0, 16'hBEEF, 1'b0);
        chk("rd_request_cleared", slave_request, 0);
        chk("rd_grant_cycles", grant_cnt, 3);
        chk("rd_strobe_cycles", rd_cnt, 1);
        chk("rd_data_ready_pulses", dr_cnt, 1);
        chk("rd_slave_ready_pulses", sr_cnt, 1);
        chk("rd_data_held", data, 16'hBEEF);

        clear_cnt();
        txn(16'h0040, 16'h00FF, 1'b1, 2, 16'h0000, 1'b0);
        chk("wr_strobe_cycles", wr_cnt, 3);
        chk("wr_no_read_strobe", rd_cnt, 0);
        chk("wr_slave_ready_pulses", sr_cnt, 1);
        chk("wr_no_data_ready", dr_cnt, 0);

        clear_cnt();
        txn(16'h0100, 16'h0000, 1'b0, -1, 16'h0000, 1'b0);
        chk("to_strobe_cycles", rd_cnt, 15);
        chk("to_bus_error_pulses", err_cnt, 1);
        chk("to_slave_ready_pulses", sr_cnt, 1);
        chk("to_no_data_ready", dr_cnt, 0);
        chk("to_data_all_ones", data, 16'hFFFF);

        clear_cnt();
        test_mode = 1'b1; bus_request = 1'b1;
        repeat (5) step();
        bus_request = 1'b0;
        step();
        test_mode = 1'b0;
        chk("tm_no_grant", grant_cnt, 0);

        clear_cnt();
        txn(16'h2000, 16'h0000, 1'b0, 3, 16'h5A5A, 1'b1);
        chk("tm_mid_slave_ready", sr_cnt, 1);
        chk("tm_mid_data_ready", dr_cnt, 1);
        chk("tm_mid_strobe_cycles", rd_cnt, 4);
        chk("tm_mid_data", data, 16'h5A5A);

        slave_address = 16'h3000; slave_write = 1'b0; bus_request = 1'b1;
        step();
        bus_request = 1'b0;
        step();
        step();
        master_valid = 1'b1; master_instruction = 8'h77;
        step();
        master_valid = 1'b0;
        chk("pre_rst_mem_read", mem_read, 1);
        chk("pre_rst_pending", slave_request, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_mem_read", mem_read, 0);
        chk("async_rst_bus_grant", bus_grant, 0);
        chk("async_rst_pending_lost", slave_request, 0);
        chk("async_rst_address", address, 0);
        step();
        reset = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
